// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings,
// arbiter state encoding, bus widths and the per-engine bus bundle.
`timescale 1ns/1ps

package sdram_pkg;

    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 16;
    localparam int CMD_W  = 4;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP      = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_ACTIVE   = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_READ     = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_WRITE    = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_B_STOP   = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_P_CHARGE = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF     = 4'b0001;

    typedef enum logic [2:0] {
        ARB_INIT  = 3'd0,
        ARB_IDLE  = 3'd1,
        ARB_AREF  = 3'd2,
        ARB_WRITE = 3'd3,
        ARB_READ  = 3'd4
    } arb_state_e;

    // Command/address bundle driven by each engine
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } sdram_bus_t;

    localparam sdram_bus_t BUS_IDLE = '{cmd: CMD_NOP, ba: '0, addr: '0};

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh request generator. Counts REF_CYCLES cycles once
// the SDRAM has been initialised, raises a refresh request on every wrap
// and flags a sticky overrun when a wrap arrives before the previous
// request was accepted.
`timescale 1ns/1ps

module sdram_ref_timer #(
    parameter int REF_CYCLES = 750,
    parameter int REF_CNT_W  = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic ack_i,
    output logic aref_req_o,
    output logic ref_overrun_o
);

    localparam logic [REF_CNT_W-1:0] CNT_LAST = REF_CNT_W'(REF_CYCLES - 1);

    logic [REF_CNT_W-1:0] cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 ovr_q, ovr_d;
    logic                 wrap;

    assign wrap = start_i && (cnt_q == CNT_LAST);

    // Next-state: an accepted request beats a coinciding wrap, which is dropped
    always_comb begin
        cnt_d = cnt_q;
        req_d = req_q;
        ovr_d = ovr_q;
        if (!start_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + REF_CNT_W'(1);
        end
        if (ack_i) begin
            req_d = 1'b0;
        end else if (wrap) begin
            req_d = 1'b1;
            if (req_q) begin
                ovr_d = 1'b1;
            end
        end
    end

    // Timer and request registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            req_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
            ovr_q <= ovr_d;
        end
    end

    assign aref_req_o    = req_q;
    assign ref_overrun_o = ovr_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Top-level SDRAM bus sequencer: grants the shared command/address/DQ bus
// to one of the init, refresh, write and read engines at a time and
// registers the selected bus onto the SDRAM pins.
// Build option: define SDRAM_ARB_RR_EN to alternate write/read priority
// when both are pending; otherwise write always beats read.
`timescale 1ns/1ps

module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = 750,
    parameter int REF_CNT_W  = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    output logic              aref_en,
    input  logic              aref_end,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_dq_oe,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              ref_overrun
);

    arb_state_e        state_q, state_d;
    sdram_bus_t        pins_q, bus_d;
    logic [DQ_W-1:0]   dq_q, dq_d;
    logic              oe_q, oe_d;
    logic              cke_q;
    logic              aref_req;
    logic              aref_ack;
    logic              last_grant_q, last_grant_d;

    // Refresh is always granted straight from IDLE when pending
    assign aref_ack = (state_q == ARB_IDLE) && aref_req;

    sdram_ref_timer #(
        .REF_CYCLES (REF_CYCLES),
        .REF_CNT_W  (REF_CNT_W)
    ) u_ref_timer (
        .clk_i         (sys_clk),
        .rst_i         (sys_rst),
        .start_i       (init_end),
        .ack_i         (aref_ack),
        .aref_req_o    (aref_req),
        .ref_overrun_o (ref_overrun)
    );

    // Next grant: refresh first, then write/read; bursts run to their end pulse
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_INIT: begin
                if (init_end) state_d = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (aref_req) begin
                    state_d = ARB_AREF;
                end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
                    state_d      = last_grant_q ? ARB_READ : ARB_WRITE;
                    last_grant_d = ~last_grant_q;
`else
                    state_d = ARB_WRITE;
`endif
                end else if (wr_req) begin
                    state_d = ARB_WRITE;
                end else if (rd_req) begin
                    state_d = ARB_READ;
                end
            end
            ARB_AREF: begin
                if (aref_end) state_d = ARB_IDLE;
            end
            ARB_WRITE: begin
                if (wr_end) state_d = ARB_IDLE;
            end
            ARB_READ: begin
                if (rd_end) state_d = ARB_IDLE;
            end
            default: state_d = ARB_INIT;
        endcase
    end

    // Bus mux driven by the current owner; data path is live only for writes
    always_comb begin
        bus_d = BUS_IDLE;
        dq_d  = '0;
        oe_d  = 1'b0;
        case (state_q)
            ARB_INIT:  bus_d = '{cmd: init_cmd, ba: init_ba, addr: init_addr};
            ARB_AREF:  bus_d = '{cmd: aref_cmd, ba: aref_ba, addr: aref_addr};
            ARB_WRITE: begin
                bus_d = '{cmd: wr_cmd, ba: wr_ba, addr: wr_addr};
                dq_d  = wr_dq;
                oe_d  = wr_dq_oe;
            end
            ARB_READ:  bus_d = '{cmd: rd_cmd, ba: rd_ba, addr: rd_addr};
            default:   bus_d = BUS_IDLE;
        endcase
    end

    // Arbiter state and registered pin drivers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ARB_INIT;
            last_grant_q <= 1'b0;
            pins_q       <= BUS_IDLE;
            dq_q         <= '0;
            oe_q         <= 1'b0;
            cke_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pins_q       <= bus_d;
            dq_q         <= dq_d;
            oe_q         <= oe_d;
            cke_q        <= 1'b1;
        end
    end

    assign aref_en = (state_q == ARB_AREF);
    assign wr_en   = (state_q == ARB_WRITE);
    assign rd_en   = (state_q == ARB_READ);

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pins_q.cmd;
    assign sdram_ba     = pins_q.ba;
    assign sdram_addr   = pins_q.addr;
    assign sdram_dq_out = dq_q;
    assign sdram_dq_oe  = oe_q;
    assign sdram_cke    = cke_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed scenarios plus a randomized run,
// every cycle compared against a transaction-level reference model.
`timescale 1ns/1ps

module tb_sdram_arbiter;

    localparam int REF = 16;

    localparam int OWN_INIT = 0;
    localparam int OWN_IDLE = 1;
    localparam int OWN_AREF = 2;
    localparam int OWN_WR   = 3;
    localparam int OWN_RD   = 4;

    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_AREF  = 4'b0001;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
    logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic        aref_en, aref_end;
    logic        wr_req, wr_en, wr_end, wr_dq_oe;
    logic [15:0] wr_dq;
    logic        rd_req, rd_en, rd_end;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        ref_overrun;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, refresh bookkeeping, expected pins
    int          mOwner   = OWN_INIT;
    int          mTimer   = 0;
    bit          mPending = 1'b0;
    bit          mOverrun = 1'b0;
    bit          mLastWr  = 1'b0;
    logic [35:0] mPins    = {C_NOP, 2'b0, 13'b0, 16'b0, 1'b0};
    int          initHold = 0;

    sdram_arbiter #(.REF_CYCLES(REF), .REF_CNT_W(5)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_en(aref_en), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end),
        .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_dq_oe(wr_dq_oe), .wr_dq(wr_dq),
        .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end),
        .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .ref_overrun(ref_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // What the pins should show one cycle after a given engine owns the bus
    function automatic logic [35:0] busOf(int owner);
        case (owner)
            OWN_INIT: return {init_cmd, init_ba, init_addr, 16'h0, 1'b0};
            OWN_AREF: return {aref_cmd, aref_ba, aref_addr, 16'h0, 1'b0};
            OWN_WR:   return {wr_cmd, wr_ba, wr_addr, wr_dq, wr_dq_oe};
            OWN_RD:   return {rd_cmd, rd_ba, rd_addr, 16'h0, 1'b0};
            default:  return {C_NOP, 2'b0, 13'b0, 16'h0, 1'b0};
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    task automatic modelStep();
        int  nxt;
        bit  wrap;
        bit  done;
        if (sys_rst) begin
            mOwner = OWN_INIT; mTimer = 0; mPending = 0; mOverrun = 0; mLastWr = 0;
            mPins  = {C_NOP, 2'b0, 13'b0, 16'h0, 1'b0};
            return;
        end
        mPins = busOf(mOwner);
        wrap  = init_end && (mTimer == REF - 1);
        done  = (mOwner == OWN_AREF && aref_end) || (mOwner == OWN_WR && wr_end) ||
                (mOwner == OWN_RD && rd_end);
        nxt   = done ? OWN_IDLE : mOwner;
        if (mOwner == OWN_INIT && init_end) nxt = OWN_IDLE;
        if (mOwner == OWN_IDLE) begin
            if (mPending) nxt = OWN_AREF;
            else if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
                nxt     = mLastWr ? OWN_RD : OWN_WR;
                mLastWr = !mLastWr;
`else
                nxt = OWN_WR;
`endif
            end
            else if (wr_req) nxt = OWN_WR;
            else if (rd_req) nxt = OWN_RD;
        end
        if (mOwner == OWN_IDLE && mPending) mPending = 0;
        else if (wrap) begin
            if (mPending) mOverrun = 1;
            mPending = 1;
        end
        mTimer = init_end ? (mTimer + 1) % REF : 0;
        mOwner = nxt;
    endtask

    task automatic stepCycle();
        @(posedge sys_clk);
        #1;
        modelStep();
        checkOutput("arefEn", aref_en, mOwner == OWN_AREF);
        checkOutput("wrEn", wr_en, mOwner == OWN_WR);
        checkOutput("rdEn", rd_en, mOwner == OWN_RD);
        checkOutput("pins", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba,
                             sdram_addr, sdram_dq_out, sdram_dq_oe, sdram_cke},
                    {mPins, 1'b1});
        checkOutput("overrun", ref_overrun, mOverrun);
    endtask

    task automatic doReset();
        sys_rst = 1; init_end = 0; wr_req = 0; rd_req = 0;
        aref_end = 0; wr_end = 0; rd_end = 0; wr_dq_oe = 0; wr_dq = '0;
        init_cmd = C_NOP; aref_cmd = C_NOP; wr_cmd = C_NOP; rd_cmd = C_NOP;
        init_ba = 0; aref_ba = 0; wr_ba = 0; rd_ba = 0;
        init_addr = 0; aref_addr = 0; wr_addr = 0; rd_addr = 0;
        stepCycle();
        stepCycle();
        sys_rst = 0;
    endtask

    // Random engine behaviour: persistent requests, end pulses mostly from owners
    task automatic applyStimulus();
        sys_rst = ($urandom_range(0, 599) == 0);
        if (sys_rst) initHold = 8;
        init_end = (initHold == 0);
        if (initHold > 0) initHold--;
        init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 13'($urandom);
        aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 13'($urandom);
        wr_cmd = 4'($urandom); wr_ba = 2'($urandom); wr_addr = 13'($urandom);
        rd_cmd = 4'($urandom); rd_ba = 2'($urandom); rd_addr = 13'($urandom);
        wr_dq = 16'($urandom); wr_dq_oe = 1'($urandom);
        if ($urandom_range(0, 7) == 0) wr_req = !wr_req;
        if ($urandom_range(0, 7) == 0) rd_req = !rd_req;
        aref_end = (mOwner == OWN_AREF) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
        wr_end   = (mOwner == OWN_WR)   ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 31) == 0);
        rd_end   = (mOwner == OWN_RD)   ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        int lat;

        // Reset state
        doReset();
        checkOutput("resetFlags", {aref_en, wr_en, rd_en, ref_overrun, sdram_cke}, 5'b00001);
        checkOutput("resetCmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_NOP);

        // Init bus passthrough, then first refresh timing
        init_cmd = C_AREF; init_ba = 2'b10; init_addr = 13'h400;
        for (int i = 0; i < 20; i++) stepCycle();
        checkOutput("initCmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_AREF);
        checkOutput("initAddr", sdram_addr, 13'h400);
        init_addr = 13'h0123;
        stepCycle();
        checkOutput("initAddrFollow", sdram_addr, 13'h0123);
        init_end = 1; init_cmd = C_NOP;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            stepCycle();
            lat++;
            if (aref_en) break;
        end
        checkOutput("arefLatency", lat, 17);
        aref_cmd = C_AREF;
        for (int i = 0; i < 4; i++) stepCycle();
        aref_end = 1;
        stepCycle();
        aref_end = 0; aref_cmd = C_NOP;
        checkOutput("arefEnDrop", aref_en, 0);
        stepCycle();
        checkOutput("idleNop", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_NOP);

        // Simultaneous write/read requests
        doReset();
        init_end = 1;
        stepCycle();
        wr_req = 1; rd_req = 1; wr_cmd = C_WRITE;
        stepCycle();
        checkOutput("pairFirst", {wr_en, rd_en}, 2'b10);
        wr_req = 0;
        for (int i = 0; i < 3; i++) stepCycle();
        wr_end = 1;
        stepCycle();
        wr_end = 0;
        checkOutput("pairGap", {wr_en, rd_en}, 2'b00);
        stepCycle();
        checkOutput("pairSecond", {wr_en, rd_en}, 2'b01);
        rd_req = 0;
        stepCycle();
        rd_end = 1;
        stepCycle();
        rd_end = 0;
        wr_req = 1; rd_req = 1;
        stepCycle();
`ifdef SDRAM_ARB_RR_EN
        checkOutput("secondPair", {wr_en, rd_en}, 2'b01);
`else
        checkOutput("secondPair", {wr_en, rd_en}, 2'b10);
`endif
        wr_req = 0; rd_req = 0; wr_end = 1; rd_end = 1;
        stepCycle();
        wr_end = 0; rd_end = 0;
        stepCycle();

        // Long read spanning two refresh wraps
        doReset();
        init_end = 1;
        stepCycle();
        rd_req = 1;
        stepCycle();
        checkOutput("longReadGrant", rd_en, 1);
        rd_req = 0;
        for (int i = 0; i < 39; i++) stepCycle();
        checkOutput("readNotPreempted", {aref_en, rd_en}, 2'b01);
        checkOutput("overrunSet", ref_overrun, 1);
        rd_end = 1;
        stepCycle();
        rd_end = 0;
        checkOutput("readEndIdle", {aref_en, rd_en}, 2'b00);
        stepCycle();
        checkOutput("arefAfterRead", aref_en, 1);
        aref_end = 1;
        stepCycle();
        aref_end = 0;
        for (int i = 0; i < 20; i++) stepCycle();
        checkOutput("overrunSticky", ref_overrun, 1);

        // Reset in the middle of a write burst
        doReset();
        init_end = 1;
        stepCycle();
        wr_req = 1; wr_cmd = C_WRITE; wr_dq_oe = 1; wr_dq = 16'hA5C3;
        stepCycle();
        stepCycle();
        checkOutput("writeDq", {sdram_dq_oe, sdram_dq_out}, {1'b1, 16'hA5C3});
        sys_rst = 1;
        stepCycle();
        checkOutput("rstDqOe", sdram_dq_oe, 0);
        checkOutput("rstCmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_NOP);
        checkOutput("rstWrEn", wr_en, 0);
        sys_rst = 0; wr_req = 0; wr_dq_oe = 0; init_end = 0; init_cmd = C_ACT;
        stepCycle();
        checkOutput("rstBackToInit", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, C_ACT);

        // Stray read-end pulse during a write
        doReset();
        init_end = 1;
        stepCycle();
        wr_req = 1;
        stepCycle();
        wr_req = 0; rd_end = 1;
        stepCycle();
        rd_end = 0;
        checkOutput("strayRdEnd", wr_en, 1);
        stepCycle();
        wr_end = 1;
        stepCycle();
        wr_end = 0;
        checkOutput("wrEndReturn", wr_en, 0);

        // Randomized traffic
        doReset();
        initHold = 5;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus();
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
